// File: rtl/vec_cfg_issue_ctrl_if.sv
// Bundle between the vector config/issue controller, the scalar core and the vector LSU.
// Handshakes: a transfer happens on a rising clk edge where valid && ready; valid-side payload holds until then.
interface vec_cfg_issue_ctrl_if #(
    parameter int XLEN = 32
);
    logic            inst_valid;
    logic            inst_ready;
    logic [XLEN-1:0] vec_inst;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;

    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] resp_rd_data;
    logic            resp_illegal;

    logic            lsu_req_valid;
    logic            lsu_req_ready;
    logic [XLEN-1:0] lsu_base;
    logic [XLEN-1:0] lsu_stride;
    logic [1:0]      lsu_mop;
    logic [2:0]      lsu_eew;
    logic [XLEN-1:0] lsu_vl;
    logic            lsu_done;

    modport slave (
        input  inst_valid, vec_inst, rs1_data, rs2_data, resp_ready, lsu_req_ready, lsu_done,
        output inst_ready, resp_valid, resp_rd_data, resp_illegal,
        output lsu_req_valid, lsu_base, lsu_stride, lsu_mop, lsu_eew, lsu_vl
    );

    modport master (
        output inst_valid, vec_inst, rs1_data, rs2_data, resp_ready, lsu_req_ready, lsu_done,
        input  inst_ready, resp_valid, resp_rd_data, resp_illegal,
        input  lsu_req_valid, lsu_base, lsu_stride, lsu_mop, lsu_eew, lsu_vl
    );
endinterface

// File: rtl/vec_cfg_issue_ctrl.sv
// Sequential vector controller: owns vl/vtype, executes vset{i}vl{i} and issues vector loads to the LSU.
// One instruction in flight; every instruction ends with exactly one response to the scalar core.
module vec_cfg_issue_ctrl #(
    parameter int XLEN       = 32,
    parameter int VLEN       = 512,
    parameter int ELEN       = 32,
    parameter int INDEXED_EN = 0
) (
    input  logic                clk,
    input  logic                reset,
    vec_cfg_issue_ctrl_if.slave bus,
    output logic [XLEN-1:0]     vl_o,
    output logic [XLEN-1:0]     vtype_o,
    output logic [2:0]          dbg_state_o
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CONF    = 3'd1,
        LD_CHK  = 3'd2,
        LD_REQ  = 3'd3,
        LD_WAIT = 3'd4,
        RESP    = 3'd5
    } state_t;

    localparam logic [XLEN-1:0] VILL   = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] VLEN_X = XLEN'(VLEN);
    localparam logic [31:0]     ELEN_W = 32'(ELEN);

    state_t          state_q;
    logic [XLEN-1:0] inst_q, rs1_q, rs2_q;
    logic [XLEN-1:0] vl_q, vtype_q;
    logic [XLEN-1:0] resp_rd_q;
    logic            resp_ill_q;
    logic            inst_ready_q, resp_valid_q, lsu_req_valid_q;

    logic            cfg_bad, vtype_bad;
    logic [XLEN-1:0] vtype_d, avl, vlmax, vl_d;
    logic [2:0]      vlmul, vsew;
    logic [31:0]     sew_bits;
    logic            ld_bad;
    logic [31:0]     ld_eew;
    logic            width_ok;

    // Config decode: vtype source and AVL selection from the latched instruction.
    always_comb begin
        cfg_bad = 1'b0;
        vtype_d = '0;
        avl     = '0;
        if (!inst_q[31])
            vtype_d = {{(XLEN-11){1'b0}}, inst_q[30:20]};
        else if (inst_q[31:30] == 2'b11)
            vtype_d = {{(XLEN-10){1'b0}}, inst_q[29:20]};
        else if (inst_q[31:25] == 7'b1000000)
            vtype_d = rs2_q;
        else
            cfg_bad = 1'b1;
        if (inst_q[31:30] == 2'b11)
            avl = {{(XLEN-5){1'b0}}, inst_q[19:15]};
        else if (inst_q[19:15] != 5'd0)
            avl = rs1_q;
        else if (inst_q[11:7] != 5'd0)
            avl = '1;
        else
            avl = vl_q;
    end

    // Fractional LMUL check: SEW > ELEN*LMUL  <=>  SEW * 2^(8-vlmul) > ELEN.
    always_comb begin
        vlmul     = vtype_d[2:0];
        vsew      = vtype_d[5:3];
        sew_bits  = 32'd8 << vsew;
        vtype_bad = (|vtype_d[XLEN-2:8]) || (vlmul == 3'b100) || (sew_bits > ELEN_W) ||
                    (vlmul[2] && ((sew_bits << (4'd8 - {1'b0, vlmul})) > ELEN_W));
        if (vlmul[2])
            vlmax = (VLEN_X >> ({1'b0, vsew} + 4'd3)) >> (4'd8 - {1'b0, vlmul});
        else
            vlmax = (VLEN_X >> ({1'b0, vsew} + 4'd3)) << vlmul[1:0];
        vl_d = (avl < vlmax) ? avl : vlmax;
    end

    always_comb begin
        width_ok = 1'b1;
        ld_eew   = 32'd0;
        case (inst_q[14:12])
            3'b000:  ld_eew = 32'd8;
            3'b101:  ld_eew = 32'd16;
            3'b110:  ld_eew = 32'd32;
            3'b111:  ld_eew = 32'd64;
            default: width_ok = 1'b0;
        endcase
        ld_bad = vtype_q[XLEN-1] || (inst_q[26] && (INDEXED_EN == 0)) ||
                 !width_ok || (ld_eew > ELEN_W);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            inst_q          <= '0;
            rs1_q           <= '0;
            rs2_q           <= '0;
            vl_q            <= '0;
            vtype_q         <= VILL;
            resp_rd_q       <= '0;
            resp_ill_q      <= 1'b0;
            inst_ready_q    <= 1'b1;
            resp_valid_q    <= 1'b0;
            lsu_req_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.inst_valid) begin
                        inst_q       <= bus.vec_inst;
                        rs1_q        <= bus.rs1_data;
                        rs2_q        <= bus.rs2_data;
                        inst_ready_q <= 1'b0;
                        if (bus.vec_inst[6:0] == 7'h57 && bus.vec_inst[14:12] == 3'b111) begin
                            state_q <= CONF;
                        end else if (bus.vec_inst[6:0] == 7'h07) begin
                            state_q <= LD_CHK;
                        end else begin
                            state_q      <= RESP;
                            resp_rd_q    <= '0;
                            resp_ill_q   <= 1'b1;
                            resp_valid_q <= 1'b1;
                        end
                    end
                end
                CONF: begin
                    state_q      <= RESP;
                    resp_valid_q <= 1'b1;
                    resp_rd_q    <= '0;
                    resp_ill_q   <= cfg_bad;
                    if (!cfg_bad) begin
                        // An unsupported vtype sets vill rather than trapping.
                        if (vtype_bad) begin
                            vtype_q <= VILL;
                            vl_q    <= '0;
                        end else begin
                            vtype_q   <= vtype_d;
                            vl_q      <= vl_d;
                            resp_rd_q <= vl_d;
                        end
                    end
                end
                LD_CHK: begin
                    resp_rd_q <= '0;
                    if (ld_bad || vl_q == '0) begin
                        state_q      <= RESP;
                        resp_ill_q   <= ld_bad;
                        resp_valid_q <= 1'b1;
                    end else begin
                        state_q         <= LD_REQ;
                        lsu_req_valid_q <= 1'b1;
                    end
                end
                LD_REQ: begin
                    if (bus.lsu_req_ready) begin
                        state_q         <= LD_WAIT;
                        lsu_req_valid_q <= 1'b0;
                    end
                end
                LD_WAIT: begin
                    if (bus.lsu_done) begin
                        state_q      <= RESP;
                        resp_rd_q    <= '0;
                        resp_ill_q   <= 1'b0;
                        resp_valid_q <= 1'b1;
                    end
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        state_q      <= IDLE;
                        resp_valid_q <= 1'b0;
                        inst_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q         <= IDLE;
                    inst_ready_q    <= 1'b1;
                    resp_valid_q    <= 1'b0;
                    lsu_req_valid_q <= 1'b0;
                end
            endcase
        end
    end

    logic unused_inst_bits;
    assign unused_inst_bits = ^inst_q[6:0];

    assign bus.inst_ready    = inst_ready_q;
    assign bus.resp_valid    = resp_valid_q;
    assign bus.resp_rd_data  = resp_rd_q;
    assign bus.resp_illegal  = resp_ill_q;
    assign bus.lsu_req_valid = lsu_req_valid_q;
    assign bus.lsu_base      = rs1_q;
    assign bus.lsu_stride    = (inst_q[27:26] == 2'b10) ? rs2_q : '0;
    assign bus.lsu_mop       = inst_q[27:26];
    assign bus.lsu_eew       = inst_q[14:12];
    assign bus.lsu_vl        = vl_q;
    assign vl_o              = vl_q;
    assign vtype_o           = vtype_q;
    assign dbg_state_o       = state_q;
endmodule
